// File: rtl/mc_control_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memory ports.
interface mc_control_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inst;
  logic            imem_ready;
  logic            dmem_ready;
  logic            imem_req;
  logic            ir_we;
  logic            dmem_req;
  logic            dmem_we;

  modport master (
    input  inst, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we
  );

  modport slave (
    output inst, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencing controller: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB with variable-latency memory handshakes.
module mc_control #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  mc_control_if.master    bus,
  input  logic            zero,
  input  logic            negative,
  output logic            pc_we,
  output logic            reg_dest,
  output logic            reg_write_enable,
  output logic            alu_src,
  output logic            mem_or_reg,
  output logic            pc_or_mem,
  output logic            link,
  output logic            branch,
  output logic            jump,
  output logic            jump_register,
  output logic            does_shift_amount_need,
  output logic            is_unsigned,
  output logic [3:0]      alu_operation,
  output logic            halted,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {CL_NOP, CL_ARITH, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_HALT} cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu;
    logic       rdst;
    logic       asrc;
    logic       uns;
    logic       shm;
    logic       lnk;
    logic       jmp;
    logic       jreg;
  } ctl_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic       reg_we;
    logic       mem_or_reg;
    logic       pc_or_mem;
    logic       link;
    logic       jump;
    logic       jump_register;
    logic       reg_dest;
    logic       alu_src;
    logic       is_unsigned;
    logic       shamt;
    logic [3:0] alu;
    logic       halted;
  } outs_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam outs_t OUT_RST = '{imem_req: 1'b1, alu: 4'd0, default: 1'b0};

  function automatic ctl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c     = '0;
    c.cls = CL_NOP;
    case (op)
      6'h00: begin
        c.cls  = CL_ARITH;
        c.rdst = 1'b1;
        case (fn)
          6'h20, 6'h21: c.alu = ALU_ADD;
          6'h22, 6'h23: c.alu = ALU_SUB;
          6'h24:        c.alu = ALU_AND;
          6'h25:        c.alu = ALU_OR;
          6'h26:        c.alu = ALU_XOR;
          6'h27:        c.alu = ALU_NOR;
          6'h2A:        c.alu = ALU_SLT;
          6'h2B:        c.alu = ALU_SLTU;
          6'h00:        begin c.alu = ALU_SLL; c.shm = 1'b1; end
          6'h02:        begin c.alu = ALU_SRL; c.shm = 1'b1; end
          6'h03:        begin c.alu = ALU_SRA; c.shm = 1'b1; end
          6'h08:        begin c.cls = CL_JUMP; c.rdst = 1'b0; c.jreg = 1'b1; end
          6'h0C:        begin c.cls = CL_HALT; c.rdst = 1'b0; end
          default:      begin c.cls = CL_NOP;  c.rdst = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.alu = ALU_ADD;  end
      6'h0A:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.alu = ALU_SLT;  end
      6'h0B:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.alu = ALU_SLTU; end
      6'h0C:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.uns = 1'b1; c.alu = ALU_AND; end
      6'h0D:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.uns = 1'b1; c.alu = ALU_OR;  end
      6'h0E:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.uns = 1'b1; c.alu = ALU_XOR; end
      6'h0F:        begin c.cls = CL_ARITH;  c.asrc = 1'b1; c.uns = 1'b1; c.alu = ALU_LUI; end
      6'h23:        begin c.cls = CL_LOAD;   c.asrc = 1'b1; c.alu = ALU_ADD;  end
      6'h2B:        begin c.cls = CL_STORE;  c.asrc = 1'b1; c.alu = ALU_ADD;  end
      6'h04, 6'h05, 6'h06, 6'h07: begin c.cls = CL_BRANCH; c.alu = ALU_SUB; end
      6'h02:        begin c.cls = CL_JUMP;   c.jmp = 1'b1; end
      6'h03:        begin c.cls = CL_JUMP;   c.jmp = 1'b1; c.lnk = 1'b1; end
      default:      c.cls = CL_NOP;
    endcase
    return c;
  endfunction

  state_e          state_r, state_nxt_s;
  logic [5:0]      op_r, fn_r;
  ctl_t            ctl_s;
  outs_t           out_r, out_nxt_s;
  logic            act_s, taken_s, branch_s, pc_we_s, ir_we_s, sw_done_s;
  logic [XLEN-1:0] instret_r;
  logic            unused_inst_s;

  assign ctl_s         = decode(op_r, fn_r);
  assign unused_inst_s = ^bus.inst;

  // Next-state sequencing driven by instruction class and memory handshakes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH:  state_nxt_s = bus.imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC: begin
        case (ctl_s.cls)
          CL_ARITH:           state_nxt_s = S_WB;
          CL_LOAD, CL_STORE:  state_nxt_s = S_MEM;
          CL_HALT:            state_nxt_s = S_HALT;
          default:            state_nxt_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) state_nxt_s = (ctl_s.cls == CL_LOAD) ? S_WB : S_FETCH;
        else                state_nxt_s = S_MEM;
      end
      S_WB:     state_nxt_s = S_FETCH;
      S_HALT:   state_nxt_s = S_HALT;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // Moore controls for the state being entered; registered so they hold for the whole state.
  always_comb begin
    out_nxt_s               = '0;
    act_s                   = (state_nxt_s == S_EXEC) || (state_nxt_s == S_MEM) || (state_nxt_s == S_WB);
    out_nxt_s.imem_req      = (state_nxt_s == S_FETCH);
    out_nxt_s.dmem_req      = (state_nxt_s == S_MEM);
    out_nxt_s.dmem_we       = (state_nxt_s == S_MEM) && (ctl_s.cls == CL_STORE);
    out_nxt_s.pc_we         = ((state_nxt_s == S_EXEC) && (ctl_s.cls inside {CL_NOP, CL_BRANCH, CL_JUMP}))
                              || (state_nxt_s == S_WB);
    out_nxt_s.reg_we        = (state_nxt_s == S_WB) || ((state_nxt_s == S_EXEC) && ctl_s.lnk);
    out_nxt_s.mem_or_reg    = (state_nxt_s == S_WB) && (ctl_s.cls == CL_LOAD);
    out_nxt_s.pc_or_mem     = (state_nxt_s == S_EXEC) && ctl_s.lnk;
    out_nxt_s.link          = (state_nxt_s == S_EXEC) && ctl_s.lnk;
    out_nxt_s.jump          = (state_nxt_s == S_EXEC) && ctl_s.jmp;
    out_nxt_s.jump_register = (state_nxt_s == S_EXEC) && ctl_s.jreg;
    out_nxt_s.reg_dest      = act_s && ctl_s.rdst;
    out_nxt_s.alu_src       = act_s && ctl_s.asrc;
    out_nxt_s.is_unsigned   = act_s && ctl_s.uns;
    out_nxt_s.shamt         = act_s && ctl_s.shm;
    out_nxt_s.alu           = act_s ? ctl_s.alu : 4'd0;
    out_nxt_s.halted        = (state_nxt_s == S_HALT);
  end

  // Branch decision follows the live ALU flags during EXEC.
  always_comb begin
    taken_s = 1'b0;
    case (op_r)
      6'h04:   taken_s = zero;
      6'h05:   taken_s = ~zero;
      6'h06:   taken_s = zero | negative;
      6'h07:   taken_s = ~zero & ~negative;
      default: taken_s = 1'b0;
    endcase
    branch_s = (state_r == S_EXEC) && (ctl_s.cls == CL_BRANCH) && taken_s;
  end

  // A store retires on the cycle its data access completes.
  assign sw_done_s = (state_r == S_MEM) && (ctl_s.cls == CL_STORE) && bus.dmem_ready;
  assign pc_we_s   = out_r.pc_we | sw_done_s;
  assign ir_we_s   = rst_b & (state_r == S_FETCH) & bus.imem_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_r <= S_FETCH;
    else        state_r <= state_nxt_s;
  end

  // Instruction latch: only opcode and funct steer the sequence.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_r <= 6'd0;
      fn_r <= 6'd0;
    end else if (ir_we_s) begin
      op_r <= bus.inst[31:26];
      fn_r <= bus.inst[5:0];
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) out_r <= OUT_RST;
    else        out_r <= out_nxt_s;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       instret_r <= '0;
    else if (pc_we_s) instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
  end

  assign bus.imem_req           = out_r.imem_req;
  assign bus.ir_we              = ir_we_s;
  assign bus.dmem_req           = out_r.dmem_req;
  assign bus.dmem_we            = out_r.dmem_we;
  assign pc_we                  = pc_we_s;
  assign reg_dest               = out_r.reg_dest;
  assign reg_write_enable       = out_r.reg_we;
  assign alu_src                = out_r.alu_src;
  assign mem_or_reg             = out_r.mem_or_reg;
  assign pc_or_mem              = out_r.pc_or_mem;
  assign link                   = out_r.link;
  assign branch                 = branch_s;
  assign jump                   = out_r.jump;
  assign jump_register          = out_r.jump_register;
  assign does_shift_amount_need = out_r.shamt;
  assign is_unsigned            = out_r.is_unsigned;
  assign alu_operation          = out_r.alu;
  assign halted                 = out_r.halted;
  assign instret                = instret_r;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized
// instruction/latency mixes compared with a table-driven reference model.
module tb_mc_control;
  localparam int XLEN = 32;
  localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_SYS = 8;

  logic clk = 1'b0;
  logic rst_b, zero, negative;
  logic pc_we, reg_dest, reg_write_enable, alu_src, mem_or_reg, pc_or_mem, link, branch;
  logic jump, jump_register, does_shift_amount_need, is_unsigned, halted;
  logic [3:0]      alu_operation;
  logic [XLEN-1:0] instret;

  mc_control_if #(.XLEN(XLEN)) bus ();

  mc_control #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus), .zero(zero), .negative(negative),
    .pc_we(pc_we), .reg_dest(reg_dest), .reg_write_enable(reg_write_enable),
    .alu_src(alu_src), .mem_or_reg(mem_or_reg), .pc_or_mem(pc_or_mem), .link(link),
    .branch(branch), .jump(jump), .jump_register(jump_register),
    .does_shift_amount_need(does_shift_amount_need), .is_unsigned(is_unsigned),
    .alu_operation(alu_operation), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    int         alu;
    bit         rd, src, uns, sh;
  } ent_t;

  ent_t tbl[$];
  int   total = 0;
  int   bad = 0;
  int   exp_instret = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_ent(input logic [5:0] op, input logic [5:0] fn, input int kind, input int alu,
                         input bit rd, input bit src, input bit uns, input bit sh);
    ent_t e;
    e.op = op; e.fn = fn; e.kind = kind; e.alu = alu;
    e.rd = rd; e.src = src; e.uns = uns; e.sh = sh;
    tbl.push_back(e);
  endtask

  function automatic ent_t lookup(input logic [31:0] w);
    ent_t r;
    r.op = w[31:26]; r.fn = w[5:0]; r.kind = K_NOP; r.alu = 0;
    r.rd = 1'b0; r.src = 1'b0; r.uns = 1'b0; r.sh = 1'b0;
    foreach (tbl[i])
      if (tbl[i].op == w[31:26] && (w[31:26] != 6'h00 || tbl[i].fn == w[5:0])) r = tbl[i];
    return r;
  endfunction

  function automatic logic [31:0] mk_word(input ent_t e);
    logic [31:0] r;
    r = $urandom;
    if (e.op == 6'h00) return {6'h00, r[25:6], e.fn};
    else               return {e.op, r[25:0]};
  endfunction

  // Branch outcome from the signed difference of the compared operands.
  function automatic bit br_taken(input logic [5:0] op, input int diff);
    case (op)
      6'h04:   return diff == 0;
      6'h05:   return diff != 0;
      6'h06:   return diff <= 0;
      default: return diff > 0;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] w, input int iwait, input int dwait, input int diff);
    ent_t e;
    int cyc = 0, fetch_n = 0, mem_n = 0, irwe_at = -1, irwe_n = 0;
    int pcw = 0, rwe = 0, dreq = 0, dwe = 0, mor = 0, base, exp_cyc;
    bit done = 1'b0, is_mem;
    logic [3:0] x_alu, d_alu;
    logic x_src, x_uns, x_sh, x_rd, x_br, x_j, x_jr, x_lnk, x_pom, x_pcw, x_rwe, d_rd, d_mor;
    e = lookup(w);
    zero = (diff == 0);
    negative = (diff < 0);
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (bus.imem_req) begin
        bus.inst = w; bus.imem_ready = (fetch_n >= iwait); fetch_n++;
      end else begin
        bus.inst = $urandom; bus.imem_ready = 1'($urandom_range(0, 1));
      end
      if (bus.dmem_req) begin
        bus.dmem_ready = (mem_n >= dwait); mem_n++;
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.ir_we) begin
        if (irwe_at < 0) irwe_at = cyc;
        irwe_n++;
      end
      if (cyc == iwait + 2) begin
        x_alu = alu_operation; x_src = alu_src; x_uns = is_unsigned; x_sh = does_shift_amount_need;
        x_rd = reg_dest; x_br = branch; x_j = jump; x_jr = jump_register; x_lnk = link;
        x_pom = pc_or_mem; x_pcw = pc_we; x_rwe = reg_write_enable;
      end
      pcw += int'(pc_we); rwe += int'(reg_write_enable); dreq += int'(bus.dmem_req);
      dwe += int'(bus.dmem_we); mor += int'(mem_or_reg);
      if (pc_we || halted) begin
        done = 1'b1; d_alu = alu_operation; d_rd = reg_dest; d_mor = mem_or_reg;
      end
      cyc++;
    end
    is_mem = (e.kind == K_LW) || (e.kind == K_SW);
    case (e.kind)
      K_ALU, K_SW, K_SYS: base = 4;
      K_LW:               base = 5;
      default:            base = 3;
    endcase
    exp_cyc = iwait + base + (is_mem ? dwait : 0);
    check("cycles", cyc, exp_cyc);
    check("ir_we_cycle", irwe_at, iwait);
    check("ir_we_count", irwe_n, 1);
    check("pc_we_count", pcw, (e.kind == K_SYS) ? 0 : 1);
    check("reg_we_count", rwe, (e.kind == K_ALU || e.kind == K_LW || e.kind == K_JAL) ? 1 : 0);
    check("dmem_req_cycles", dreq, is_mem ? dwait + 1 : 0);
    check("dmem_we_cycles", dwe, (e.kind == K_SW) ? dwait + 1 : 0);
    check("mem_or_reg_cycles", mor, (e.kind == K_LW) ? 1 : 0);
    check("exec_alu", x_alu, e.alu);
    check("exec_alu_src", x_src, e.src);
    check("exec_unsigned", x_uns, e.uns);
    check("exec_shamt", x_sh, e.sh);
    check("exec_branch", x_br, (e.kind == K_BR) && br_taken(e.op, diff));
    check("exec_jump", x_j, (e.kind == K_J) || (e.kind == K_JAL));
    check("exec_jr", x_jr, e.kind == K_JR);
    check("exec_link", x_lnk, e.kind == K_JAL);
    check("exec_pc_or_mem", x_pom, e.kind == K_JAL);
    check("exec_reg_we", x_rwe, e.kind == K_JAL);
    check("exec_pc_we", x_pcw, e.kind inside {K_NOP, K_BR, K_J, K_JAL, K_JR});
    if (e.kind inside {K_ALU, K_LW, K_SW, K_BR}) check("exec_reg_dest", x_rd, e.rd);
    if (e.kind == K_ALU || e.kind == K_LW) begin
      check("wb_alu", d_alu, e.alu);
      check("wb_reg_dest", d_rd, e.rd);
      check("wb_mem_or_reg", d_mor, e.kind == K_LW);
    end
    check("halted", halted, e.kind == K_SYS);
    if (e.kind != K_SYS) begin
      exp_instret++;
      @(posedge clk);
      #1;
    end
    check("instret", instret, exp_instret);
  endtask

  initial begin
    ent_t e;
    logic [31:0] w;
    bit seen;
    add_ent(6'h00, 6'h20, K_ALU, 0, 1, 0, 0, 0);  add_ent(6'h00, 6'h21, K_ALU, 0, 1, 0, 0, 0);
    add_ent(6'h00, 6'h22, K_ALU, 1, 1, 0, 0, 0);  add_ent(6'h00, 6'h23, K_ALU, 1, 1, 0, 0, 0);
    add_ent(6'h00, 6'h24, K_ALU, 2, 1, 0, 0, 0);  add_ent(6'h00, 6'h25, K_ALU, 3, 1, 0, 0, 0);
    add_ent(6'h00, 6'h26, K_ALU, 4, 1, 0, 0, 0);  add_ent(6'h00, 6'h27, K_ALU, 5, 1, 0, 0, 0);
    add_ent(6'h00, 6'h2A, K_ALU, 6, 1, 0, 0, 0);  add_ent(6'h00, 6'h2B, K_ALU, 7, 1, 0, 0, 0);
    add_ent(6'h00, 6'h00, K_ALU, 8, 1, 0, 0, 1);  add_ent(6'h00, 6'h02, K_ALU, 9, 1, 0, 0, 1);
    add_ent(6'h00, 6'h03, K_ALU, 10, 1, 0, 0, 1); add_ent(6'h00, 6'h08, K_JR, 0, 0, 0, 0, 0);
    add_ent(6'h00, 6'h0C, K_SYS, 0, 0, 0, 0, 0);
    add_ent(6'h08, 6'h00, K_ALU, 0, 0, 1, 0, 0);  add_ent(6'h09, 6'h00, K_ALU, 0, 0, 1, 0, 0);
    add_ent(6'h0A, 6'h00, K_ALU, 6, 0, 1, 0, 0);  add_ent(6'h0B, 6'h00, K_ALU, 7, 0, 1, 0, 0);
    add_ent(6'h0C, 6'h00, K_ALU, 2, 0, 1, 1, 0);  add_ent(6'h0D, 6'h00, K_ALU, 3, 0, 1, 1, 0);
    add_ent(6'h0E, 6'h00, K_ALU, 4, 0, 1, 1, 0);  add_ent(6'h0F, 6'h00, K_ALU, 11, 0, 1, 1, 0);
    add_ent(6'h23, 6'h00, K_LW, 0, 0, 1, 0, 0);   add_ent(6'h2B, 6'h00, K_SW, 0, 0, 1, 0, 0);
    add_ent(6'h04, 6'h00, K_BR, 1, 0, 0, 0, 0);   add_ent(6'h05, 6'h00, K_BR, 1, 0, 0, 0, 0);
    add_ent(6'h06, 6'h00, K_BR, 1, 0, 0, 0, 0);   add_ent(6'h07, 6'h00, K_BR, 1, 0, 0, 0, 0);
    add_ent(6'h02, 6'h00, K_J, 0, 0, 0, 0, 0);    add_ent(6'h03, 6'h00, K_JAL, 0, 0, 0, 0, 0);

    // Reset with both readies high: everything but imem_req must stay quiet.
    rst_b = 1'b0; zero = 1'b1; negative = 1'b0;
    bus.inst = 32'h00221820; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    #12;
    check("rst_imem_req", bus.imem_req, 1'b1);
    check("rst_ir_we", bus.ir_we, 1'b0);
    check("rst_pc_we", pc_we, 1'b0);
    check("rst_dmem_req", bus.dmem_req, 1'b0);
    check("rst_reg_we", reg_write_enable, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_instret", instret, 0);
    check("rst_alu", alu_operation, 4'd0);
    @(negedge clk);
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; rst_b = 1'b1;

    run_instr(32'h00221820, 0, 0, 1);   // add $3,$1,$2
    run_instr(32'h8C430004, 0, 3, 1);   // lw, three wait cycles
    run_instr(32'h10220003, 0, 0, 0);   // beq taken
    run_instr(32'h10220003, 0, 0, 1);   // beq not taken
    run_instr(32'h0C000010, 0, 0, 1);   // jal
    run_instr(32'h03E00008, 1, 0, 1);   // jr
    run_instr(32'h08000020, 0, 0, 1);   // j
    run_instr(32'h18400002, 2, 0, -1);  // blez on negative
    run_instr(32'h1C400002, 0, 0, 0);   // bgtz on zero
    run_instr(32'hAC430008, 0, 2, 1);   // sw, two wait cycles
    run_instr(32'hFC000000, 0, 0, 1);   // unknown opcode
    run_instr(32'h00000000, 0, 0, 1);   // sll nop
    run_instr(32'h3C01ABCD, 3, 0, 1);   // lui

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) w = $urandom;
      else w = mk_word(tbl[$urandom_range(0, tbl.size() - 1)]);
      e = lookup(w);
      if (e.kind == K_SYS) w[0] = ~w[0];
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2) - 1);
    end

    // Reset mid-store: nothing of the aborted sw may retire.
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      bus.inst = 32'hAC430008; bus.imem_ready = bus.imem_req; bus.dmem_ready = 1'b0;
      #1;
      seen = bus.dmem_req;
    end
    check("sw_reached_mem", seen, 1'b1);
    @(negedge clk);
    rst_b = 1'b0; bus.imem_ready = 1'b0;
    #1;
    check("abort_imem_req", bus.imem_req, 1'b1);
    check("abort_dmem_req", bus.dmem_req, 1'b0);
    check("abort_dmem_we", bus.dmem_we, 1'b0);
    check("abort_pc_we", pc_we, 1'b0);
    check("abort_instret", instret, 0);
    exp_instret = 0;
    @(negedge clk);
    rst_b = 1'b1;
    run_instr(32'h00221820, 0, 0, 1);

    run_instr(32'h0000000C, 1, 0, 1);   // syscall
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.inst = $urandom; bus.imem_ready = 1'($urandom_range(0, 1));
      bus.dmem_ready = 1'($urandom_range(0, 1));
      #1;
      check("halt_imem_req", bus.imem_req, 1'b0);
      check("halt_pc_we", pc_we, 1'b0);
      check("halt_halted", halted, 1'b1);
      check("halt_instret", instret, exp_instret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
